// File: rtl/smaesh_input_loader_pkg.sv
// Shared definitions for the masked-AES input loader: FSM states,
// word-count constants and the share-word width helper.
`ifndef SMAESH_INPUT_LOADER_PKG_SV
`define SMAESH_INPUT_LOADER_PKG_SV

// Width of one shared 32-bit column (all d shares of 32 bits).
`define SMAESH_SW(d) (32 * (d))

package smaesh_input_loader_pkg;

    localparam int NSHARES = 2;

    // Number of 32-bit key words for each key length and data words per block.
    localparam int NKW128  = 4;
    localparam int NKW192  = 6;
    localparam int NKW256  = 8;
    localparam int NDW     = 4;
    localparam int NKW_MAX = NKW256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEY     = 2'd1,
        ST_DATA    = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

endpackage

`endif

// File: rtl/smaesh_share_wordbank.sv
// Bank of NW shared words. Word-indexed write, synchronous clear to an
// all-zero sharing and asynchronous reset. Shares are stored verbatim.
module smaesh_share_wordbank #(
    parameter int D  = 2,
    parameter int NW = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         we_i,
    input  logic [$clog2(NW)-1:0]        waddr_i,
    input  logic [`SMAESH_SW(D)-1:0]     wdata_i,
    output logic [`SMAESH_SW(D)*NW-1:0]  words_o
);

    localparam int SW = `SMAESH_SW(D);

    logic [SW-1:0] bank_q [NW];

    // Word storage: reset and clear dominate, then the indexed write.
    // NOTE: this array holds secret shares, so it gets a real reset and clear
    // rather than being left uninitialised like an ordinary RAM.
    // NOTE: sequential state is updated with <= only, so every register sees
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) bank_q[k] <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < NW; k++) bank_q[k] <= '0;
        end else if (we_i) begin
            bank_q[waddr_i] <= wdata_i;
        end
    end

    // Flatten the bank: word k occupies words_o[SW*k +: SW].
    for (genvar k = 0; k < NW; k++) begin : g_flat
        assign words_o[SW*k +: SW] = bank_q[k];
    end

endmodule

// File: rtl/smaesh_input_loader.sv
// Staging stage in front of the masked AES core: collects a command and a
// stream of shared 32-bit columns into the key and plaintext banks, then
// hands them to the core on a valid/ready handshake.
module smaesh_input_loader
    import smaesh_input_loader_pkg::*;
#(
    parameter int d = NSHARES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_new_key,
    input  logic                      cmd_mode_256,
    input  logic                      cmd_mode_192,
    input  logic                      cmd_inverse,
    input  logic                      cmd_ksonly,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [`SMAESH_SW(d)-1:0]  s_data,
    output logic                      core_valid_in,
    input  logic                      core_in_ready,
    output logic [128*d-1:0]          core_sh_data_in,
    output logic [256*d-1:0]          core_sh_key,
    output logic                      core_inverse,
    output logic                      core_key_schedule_only,
    output logic                      core_mode_256,
    output logic                      core_mode_192,
    output logic                      err
);

    state_e     state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [3:0] nkw_q, nkw_d;
    logic       key_valid_q, key_valid_d;
    logic       mode_256_q, mode_256_d;
    logic       mode_192_q, mode_192_d;
    logic       inverse_q, inverse_d;
    logic       ksonly_q, ksonly_d;
    logic       err_q, err_d;

    logic       key_clr, key_we;
    logic       data_clr, data_we;

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            nkw_q       <= '0;
            key_valid_q <= 1'b0;
            mode_256_q  <= 1'b0;
            mode_192_q  <= 1'b0;
            inverse_q   <= 1'b0;
            ksonly_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            nkw_q       <= nkw_d;
            key_valid_q <= key_valid_d;
            mode_256_q  <= mode_256_d;
            mode_192_q  <= mode_192_d;
            inverse_q   <= inverse_d;
            ksonly_q    <= ksonly_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic and bank write/clear strobes.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        nkw_d       = nkw_q;
        key_valid_d = key_valid_q;
        mode_256_d  = mode_256_q;
        mode_192_d  = mode_192_q;
        inverse_d   = inverse_q;
        ksonly_d    = ksonly_q;
        err_d       = 1'b0;
        key_clr     = 1'b0;
        key_we      = 1'b0;
        data_clr    = 1'b0;
        data_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    inverse_d = cmd_inverse;
                    ksonly_d  = cmd_ksonly;
                    if (cmd_new_key) begin
                        // 256 dominates 192 so the core never sees both flags.
                        mode_256_d  = cmd_mode_256;
                        mode_192_d  = cmd_mode_192 & ~cmd_mode_256;
                        nkw_d       = cmd_mode_256 ? 4'(NKW256) :
                                      cmd_mode_192 ? 4'(NKW192) : 4'(NKW128);
                        key_clr     = 1'b1;
                        key_valid_d = 1'b0;
                        wcnt_d      = '0;
                        state_d     = ST_KEY;
                    end else if (!key_valid_q || cmd_ksonly) begin
                        err_d = 1'b1;
                    end else begin
                        wcnt_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_KEY: begin
                if (s_valid) begin
                    key_we = 1'b1;
                    if ({1'b0, wcnt_q} == nkw_q - 4'd1) begin
                        key_valid_d = 1'b1;
                        wcnt_d      = '0;
                        state_d     = ksonly_q ? ST_PRESENT : ST_DATA;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_valid) begin
                    data_we = 1'b1;
                    if (wcnt_q == 3'(NDW - 1)) begin
                        wcnt_d  = '0;
                        state_d = ST_PRESENT;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            ST_PRESENT: begin
                if (core_in_ready) begin
                    data_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    smaesh_share_wordbank #(.D(d), .NW(NDW)) u_data_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (data_clr),
        .we_i    (data_we),
        .waddr_i (wcnt_q[1:0]),
        .wdata_i (s_data),
        .words_o (core_sh_data_in)
    );

    smaesh_share_wordbank #(.D(d), .NW(NKW_MAX)) u_key_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (key_clr),
        .we_i    (key_we),
        .waddr_i (wcnt_q),
        .wdata_i (s_data),
        .words_o (core_sh_key)
    );

    assign cmd_ready              = (state_q == ST_IDLE);
    assign s_ready                = (state_q == ST_KEY) || (state_q == ST_DATA);
    assign core_valid_in          = (state_q == ST_PRESENT);
    assign core_inverse           = inverse_q;
    assign core_key_schedule_only = ksonly_q;
    assign core_mode_256          = mode_256_q;
    assign core_mode_192          = mode_192_q;
    assign err                    = err_q;

endmodule
